// File: rtl/bitrev_prng_ctrl_pkg.sv
// Shared definitions for the bit-reversal PRNG sequencer: state encodings,
// LFSR reset value and taps, and the LFSR step function.
package bitrev_prng_ctrl_pkg;

  localparam int         COUNT_W  = 8;
  localparam logic [3:0] LFSR_RST = 4'b0001;
  localparam int         TAP_A    = 3;
  localparam int         TAP_B    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fibonacci LFSR for x^4+x^3+1; a nonzero state never reaches zero.
  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction

endpackage

// File: rtl/bitrev_prng_ctrl_if.sv
// Control request and random-word stream between the register block,
// the PRNG sequencer (slave) and the consumer side (master).
interface bitrev_prng_ctrl_if;
  import bitrev_prng_ctrl_pkg::*;

  logic               start;
  logic [3:0]         seed;
  logic [COUNT_W-1:0] count;
  logic               abort;
  logic [3:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               err_seed;

  modport slave (
    input  start, seed, count, abort, out_ready,
    output out_data, out_valid, out_last, busy, done, err_seed
  );

  modport master (
    output start, seed, count, abort, out_ready,
    input  out_data, out_valid, out_last, busy, done, err_seed
  );

endinterface

// File: rtl/bitrev_prng_ctrl_lut.sv
// 4-bit bit-reversal table used to scramble the LFSR state.
module bitrev_prng_ctrl_lut (
  input  logic [3:0] addr,
  output logic [3:0] data
);

  always_comb begin
    data = 4'b0000;
    case (addr)
      4'b0000: data = 4'b0000;
      4'b0001: data = 4'b1000;
      4'b0010: data = 4'b0100;
      4'b0011: data = 4'b1100;
      4'b0100: data = 4'b0010;
      4'b0101: data = 4'b1010;
      4'b0110: data = 4'b0110;
      4'b0111: data = 4'b1110;
      4'b1000: data = 4'b0001;
      4'b1001: data = 4'b1001;
      4'b1010: data = 4'b0101;
      4'b1011: data = 4'b1101;
      4'b1100: data = 4'b0011;
      4'b1101: data = 4'b1011;
      4'b1110: data = 4'b0111;
      4'b1111: data = 4'b1111;
      default: data = 4'b0000;
    endcase
  end

endmodule

// File: rtl/bitrev_prng_ctrl.sv
// PRNG sequencer: seeds a 4-bit LFSR on start, streams bit-reversed states
// on a valid/ready channel for a programmed word count, then pulses done.
module bitrev_prng_ctrl
  import bitrev_prng_ctrl_pkg::*;
(
  input logic                clk,
  input logic                rst,
  bitrev_prng_ctrl_if.slave  bus
);

  state_e             state_q, state_d;
  logic [3:0]         lfsr_q, lfsr_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_seed_q, err_seed_d;
  logic [3:0]         lut_data;
  logic               transfer;

  bitrev_prng_ctrl_lut u_lut (
    .addr (lfsr_q),
    .data (lut_data)
  );

  assign transfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_seed_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.seed == 4'd0) begin
            err_seed_d = 1'b1;
          end else begin
            lfsr_d = bus.seed;
            busy_d = 1'b1;
            if (bus.count == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              remaining_d = bus.count;
              state_d     = ST_RUN;
              out_valid_d = 1'b1;
            end
          end
        end
      end

      // Abort beats a simultaneous transfer: that word is treated as undelivered.
      ST_RUN: begin
        if (bus.abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          remaining_d = '0;
        end else if (transfer) begin
          lfsr_d      = lfsr_next(lfsr_q);
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= LFSR_RST;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_seed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_seed_q  <= err_seed_d;
    end
  end

  assign bus.out_data  = out_valid_q ? lut_data : 4'd0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_valid_q & (remaining_q == COUNT_W'(1));
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_seed  = err_seed_q;

endmodule
